// File: rtl/store_half_narrow_pkg.sv
// Shared types and constants for the 32->16 store narrowing unit.
// Store size codes, FSM state encoding and an alignment helper.
package store_half_narrow_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int HALF_W_DEF = 16;
    localparam int ADDR_W_DEF = 32;

    localparam logic SZ_HALF = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    // Halfword stores need bit 0 clear, word stores need bits 1:0 clear.
    function automatic logic is_aligned(
        input logic [1:0] lsb,
        input logic       size
    );
        if (size == SZ_WORD) begin
            is_aligned = (lsb == 2'b00);
        end else begin
            is_aligned = (lsb[0] == 1'b0);
        end
    endfunction

endpackage

// File: rtl/store_half_narrow_if.sv
// Store-side handshake and halfword memory write port bundle.
// master: MEM stage + memory side; slave: the narrowing unit.
interface store_half_narrow_if
    import store_half_narrow_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HALF_W = HALF_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              in_size;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [HALF_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              busy;
    logic              ovf;
    logic              align_err;

    modport master (
        output in_valid, in_data, in_addr, in_size, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  busy, ovf, align_err
    );

    modport slave (
        input  in_valid, in_data, in_addr, in_size, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output busy, ovf, align_err
    );

endinterface

// File: rtl/store_half_narrow.sv
// Narrows 32-bit MEM-stage stores onto a 16-bit memory write port.
// Ports: clk, reset (sync, active-high), bus (store_half_narrow_if.slave).
module store_half_narrow
    import store_half_narrow_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HALF_W = HALF_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic               clk,
    input logic               reset,
    store_half_narrow_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              size_q, size_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [HALF_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ovf_q, ovf_d;
    logic              align_err_q, align_err_d;
    logic              busy_q, busy_d;

    logic accept;
    logic aligned;
    logic no_fit;

    assign bus.in_ready = (state_q == ST_IDLE) && !reset;
    assign accept = bus.in_valid && bus.in_ready;
    assign aligned = is_aligned(bus.in_addr[1:0], bus.in_size);

    // Upper half must replicate bit 15 for the value to survive truncation.
    assign no_fit = data_d[DATA_W-1:HALF_W] != {HALF_W{data_d[HALF_W-1]}};

    // State and capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            addr_q      <= '0;
            size_q      <= SZ_HALF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ovf_q       <= 1'b0;
            align_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ovf_q       <= ovf_d;
            align_err_q <= align_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next state and capture
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        size_d  = size_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d = bus.in_data;
                    addr_d = bus.in_addr;
                    size_d = bus.in_size;
                    // Misaligned stores are swallowed here.
                    if (aligned) begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (bus.mem_ack) begin
                    if (size_q == SZ_WORD) begin
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HI: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so the
    // first beat appears the cycle after accept.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ovf_d       = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        align_err_d = accept && !aligned;
        unique case (state_d)
            ST_IDLE: begin
                mem_we_d = 1'b0;
            end
            ST_LO: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_d;
                mem_wdata_d = data_d[HALF_W-1:0];
                ovf_d       = (size_d == SZ_HALF) && no_fit;
            end
            ST_HI: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_d + ADDR_W'(2);
                mem_wdata_d = data_d[DATA_W-1:HALF_W];
            end
            default: mem_we_d = 1'b0;
        endcase
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ovf       = ovf_q;
    assign bus.align_err = align_err_q;
    assign bus.busy      = busy_q;

endmodule
